cv32e40p_apu_arbiter: RTL and testbench

// - Shares one APU (shared FPU/accelerator) between NUM_REQ requesting cores over the apu-interconnect.
// - Sits between the per-core EX-stage APU ports (req/gnt, operands/op, rvalid/result) and the single unit port.
// - Round-robin arbitration on the request channel. An in-order tag FIFO routes each response back to its issuer.

---
 rtl/cv32e40p_apu_arbiter.sv | 152 +++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_apu_arbiter.sv
// cv32e40p_apu_arbiter
// Lets NUM_REQ cores share one APU. Requests are arbitrated round-robin. An
// in-order tag FIFO remembers which core issued each accepted request, so that
// every unit response (rvalid) is sent back to the core that issued it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i / gnt_o     per-core request and grant (grant is one-hot or zero)
//   operands_i, op_i  per-core flattened operands and opcode
//   rvalid_o          per-core response valid (one-hot or zero)
//   result_o, flags_o unit response, broadcast to all cores
//   apu_*             single unit-side port (req/gnt, operands/op, rvalid/result/flags)
//   busy_o            tag FIFO holds outstanding requests
//   err_o             sticky: a response arrived while no request was outstanding
//   perf_stall_o      per-core 16-bit stall counters
//
// Optional feature: define CV32E40P_APU_ARB_PERF_EN to build the stall
// counters. Without it, perf_stall_o is tied to zero.

`ifdef CV32E40P_APU_ARB_PERF_EN
// One saturating counter per core. It counts the cycles where the core
// requests but is not granted.
module cv32e40p_apu_arbiter_stall_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [15:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (stall && cnt != 16'hFFFF)
            cnt <= cnt + 1'b1;
    end
endmodule
`endif

module cv32e40p_apu_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    input  logic [NUM_REQ*APU_NARGS_CPU*32-1:0] operands_i,
    input  logic [NUM_REQ*APU_WOP_CPU-1:0]      op_i,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [31:0]                         result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]         flags_o,
    output logic                                apu_req_o,
    input  logic                                apu_gnt_i,
    output logic [APU_NARGS_CPU*32-1:0]         apu_operands_o,
    output logic [APU_WOP_CPU-1:0]              apu_op_o,
    input  logic                                apu_rvalid_i,
    input  logic [31:0]                         apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_i,
    output logic                                busy_o,
    output logic                                err_o,
    output logic [NUM_REQ*16-1:0]               perf_stall_o
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int OPND_W = APU_NARGS_CPU * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);

    logic [IDX_W-1:0] rr_ptr, winner;
    logic             any_req, fifo_full, push, pop;
    logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             err_q;

    // Scan upward from rr_ptr with wrap. The first requesting core wins.
    // The sum can be at most 2*NUM_REQ-2, so one extra bit is enough.
    always_comb begin : pick
        logic [IDX_W:0] sum;
        logic           found;
        sum    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= NREQ_EXT) sum = sum - NREQ_EXT;
            if (!found && req_i[IDX_W'(sum)]) begin
                found  = 1'b1;
                winner = IDX_W'(sum);
            end
        end
    end

    assign any_req   = |req_i;
    assign fifo_full = (count == FULL_CNT);
    // A full FIFO blocks issue even when a pop happens in the same cycle.
    // This keeps the full flag a pure register decode.
    assign apu_req_o = any_req & ~fifo_full;
    assign push      = apu_req_o & apu_gnt_i;
    assign pop       = apu_rvalid_i & (count != '0);

    assign gnt_o          = push ? (NUM_REQ'(1) << winner) : '0;
    assign apu_operands_o = any_req ? operands_i[int'(winner)*OPND_W +: OPND_W] : '0;
    assign apu_op_o       = any_req ? op_i[int'(winner)*APU_WOP_CPU +: APU_WOP_CPU] : '0;

    assign rvalid_o = pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
    assign result_o = apu_result_i;
    assign flags_o  = apu_flags_i;
    assign busy_o   = (count != '0);
    assign err_o    = err_q;

    // Tag storage is not reset. Entries are valid only between the read and write pointers.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (apu_rvalid_i && count == '0) err_q <= 1'b1;
        end
    end

`ifdef CV32E40P_APU_ARB_PERF_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        cv32e40p_apu_arbiter_stall_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .stall (req_i[i] & ~gnt_o[i]),
            .cnt   (perf_stall_o[i*16 +: 16])
        );
    end
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for cv32e40p_apu_arbiter with the default parameters
// (4 cores, 4 outstanding tags). Each expected grant pushes its core index
// onto a scoreboard queue. Each response pops the queue and must be routed
// back to that core.
module tb_cv32e40p_apu_arbiter;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic            apu_gnt, apu_rvalid;
    logic [NR*96-1:0] operands;
    logic [NR*6-1:0] op;
    logic [31:0]     apu_result;
    logic [4:0]      apu_flags;
    logic [NR-1:0]   gnt_o, rvalid_o;
    logic [31:0]     result_o;
    logic [4:0]      flags_o;
    logic            apu_req_o, busy_o, err_o;
    logic [95:0]     apu_operands_o;
    logic [5:0]      apu_op_o;
    logic [NR*16-1:0] perf_stall_o;

    logic [95:0] opm [NR];
    logic [5:0]  opv [NR];
    int          exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cv32e40p_apu_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt_o),
        .operands_i(operands), .op_i(op), .rvalid_o(rvalid_o),
        .result_o(result_o), .flags_o(flags_o), .apu_req_o(apu_req_o),
        .apu_gnt_i(apu_gnt), .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
        .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result), .apu_flags_i(apu_flags),
        .busy_o(busy_o), .err_o(err_o), .perf_stall_o(perf_stall_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle, checks the combinational outputs, then advances to
    // just after the next clock edge.
    task automatic step(input logic [NR-1:0] r, input logic g, input logic rv,
                        input logic [NR-1:0] eg);
        logic [31:0] res;
        logic [4:0]  fl;
        int          e;
        res = $urandom;
        fl  = 5'($urandom);
        req = r; apu_gnt = g; apu_rvalid = rv; apu_result = res; apu_flags = fl;
        #1;
        chk("gnt", gnt_o, eg);
        if (rv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid", rvalid_o, NR'(1) << e);
            chk("result", result_o, res);
            chk("flags", flags_o, fl);
        end else begin
            chk("rvalid_idle", rvalid_o, 0);
        end
        if (eg != 0) begin
            e = oh2i(eg);
            exp_q.push_back(e);
            chk("operands", apu_operands_o, opm[e]);
            chk("op", apu_op_o, opv[e]);
        end
        tick();
    endtask

    task automatic do_reset();
        req = '0; apu_gnt = 1'b0; apu_rvalid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            opm[i] = {32'hA0A0_0000 | 32'(i), 32'hB0B0_0000 | 32'(i), 32'hC0C0_0000 | 32'(i)};
            opv[i] = 6'(i * 5 + 3);
            operands[i*96 +: 96] = opm[i];
            op[i*6 +: 6] = opv[i];
        end
        rst_n = 1'b0; req = '0; apu_gnt = 1'b0; apu_rvalid = 1'b0;
        apu_result = '0; apu_flags = '0;
        #3;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_apu_req", apu_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_perf", perf_stall_o, 0);
        tick();
        rst_n = 1'b1;

        // Single core: grant in the same cycle, response 3 cycles later.
        step(4'b0001, 1'b1, 1'b0, 4'b0001);
        chk("single_busy", busy_o, 1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000);
        chk("idle_apu_req", apu_req_o, 0);
        chk("idle_operands", apu_operands_o, 0);
        chk("idle_op", apu_op_o, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("single_busy_done", busy_o, 0);

        // Round-robin from pointer 0. Responses keep the FIFO from filling.
        do_reset();
        step(4'b1111, 1'b1, 1'b0, 4'b0001);
        step(4'b1111, 1'b1, 1'b1, 4'b0010);
        step(4'b1111, 1'b1, 1'b1, 4'b0100);
        step(4'b1111, 1'b1, 1'b1, 4'b1000);
        step(4'b1111, 1'b1, 1'b1, 4'b0001);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("rr_busy_done", busy_o, 0);

        // Fill the FIFO (pointer is now 1). A pop in the same cycle as full still blocks issue.
        step(4'b1111, 1'b1, 1'b0, 4'b0010);
        step(4'b1111, 1'b1, 1'b0, 4'b0100);
        step(4'b1111, 1'b1, 1'b0, 4'b1000);
        step(4'b1111, 1'b1, 1'b0, 4'b0001);
        chk("full_apu_req", apu_req_o, 0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000);
        step(4'b1111, 1'b1, 1'b0, 4'b0010);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("full_busy_done", busy_o, 0);

        // Issue order core2, core0, core3 (pointer is now 2).
        step(4'b0100, 1'b1, 1'b0, 4'b0100);
        step(4'b0001, 1'b1, 1'b0, 4'b0001);
        step(4'b1000, 1'b1, 1'b0, 4'b1000);
        // Unit withholds the grant. Pointer 0 makes core1 the winner of 0110.
        req = 4'b0110; apu_gnt = 1'b0; apu_rvalid = 1'b0;
        #1;
        chk("hold_apu_req", apu_req_o, 1);
        chk("hold_gnt", gnt_o, 0);
        chk("hold_operands", apu_operands_o, opm[1]);
        chk("hold_op", apu_op_o, opv[1]);
        tick();
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("order_busy1", busy_o, 1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("order_busy2", busy_o, 1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("order_busy3", busy_o, 0);

        // Stray response with an empty FIFO sets err_o, which stays set until reset.
        step(4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("err_set", err_o, 1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000);
        chk("err_held", err_o, 1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", err_o, 0);
        chk("rst2_busy", busy_o, 0);
        tick();
        rst_n = 1'b1;

        // Cores 0 and 1 stall for 5 cycles while the unit withholds the grant.
        req = 4'b0011; apu_gnt = 1'b0; apu_rvalid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        req = 4'b0000;
`ifdef CV32E40P_APU_ARB_PERF_EN
        chk("perf_core0", perf_stall_o[15:0], 5);
        chk("perf_core1", perf_stall_o[31:16], 5);
        chk("perf_core2", perf_stall_o[47:32], 0);
`else
        chk("perf_tied", perf_stall_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
